// File: rtl/hes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hes_pkg
//  Purpose  : Shared definitions for the HES stream cipher (encrypt and
//             decrypt sides): 256-entry substitution table, controller state
//             encoding and the default maximum message length.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package hes_pkg;

    // Default maximum message length in bytes (legal range 1..256)
    localparam int HES_MAX_LEN_DEFAULT = 256;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } hes_state_e;

    // Substitution table; the first element of the concatenation is entry 0
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage : hes_pkg
`default_nettype wire

// File: rtl/hes_keystream_gen.sv
`default_nettype none
// ============================================================================
//  Module   : hes_keystream_gen
//  Purpose  : Combinational keystream byte: SBOX[(key + byte_idx) mod 256].
//  Ports    : key      in  8  latched message key
//             byte_idx in  8  position of the byte within the message
//             ks       out 8  keystream byte
//  Revision : 1.0 - initial release
// ============================================================================
module hes_keystream_gen
    import hes_pkg::*;
(
    input  logic [7:0] key,
    input  logic [7:0] byte_idx,
    output logic [7:0] ks
);

    logic [7:0] w_addr;

    // 8-bit sum, so 0xFF + 1 wraps to 0x00
    assign w_addr = key + byte_idx;
    assign ks     = SBOX[w_addr];

endmodule : hes_keystream_gen
`default_nettype wire

// File: rtl/hes_stream_decipher.sv
`default_nettype none
// ============================================================================
//  Module   : hes_stream_decipher
//  Purpose  : Byte-stream decipher. Each accepted ciphertext byte is XORed
//             with the keystream byte for its position and presented on a
//             single output register stage (valid/ready on both sides).
//  Ports    : clk, rst                 clock, synchronous active-high reset
//             key, new_message         key sampled on the new_message pulse
//             in_valid/in_ready/in_data/in_last     ciphertext handshake
//             out_valid/out_ready/out_data/out_last plaintext handshake
//             busy, done, len_err      status (len_err is sticky)
//  Revision : 1.0 - initial release
// ============================================================================
module hes_stream_decipher
    import hes_pkg::*;
#(
    parameter int MAX_LEN = HES_MAX_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key,
    input  logic       new_message,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy,
    output logic       done,
    output logic       len_err
);

    // Index of the byte that completes a maximum-length message
    localparam logic [7:0] c_last_idx = 8'(MAX_LEN - 1);

    hes_state_e state_q, state_d;
    logic [7:0] key_q, key_d;
    logic [7:0] idx_q, idx_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_last_q, out_last_d;
    logic       busy_q, busy_d;
    logic       len_err_q, len_err_d;

    logic       w_in_ready;
    logic       w_accept;
    logic       w_overflow;
    logic       w_done;
    logic [7:0] w_ks;

    hes_keystream_gen u_ksgen (
        .key      (key_q),
        .byte_idx (idx_q),
        .ks       (w_ks)
    );

    always_comb begin
        // A new byte may enter when the output stage is empty or draining;
        // a new_message cycle never accepts data.
        w_in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready) && !new_message;
        w_accept   = in_valid && w_in_ready;
        w_overflow = w_accept && !in_last && (idx_q == c_last_idx);
        w_done     = out_valid_q && out_ready && out_last_q;

        state_d     = state_q;
        key_d       = key_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        len_err_d   = len_err_q;

        if (new_message) begin
            // Start (or restart) a message; any unsent output byte is dropped
            state_d     = ST_RUN;
            key_d       = key;
            idx_d       = 8'h00;
            out_valid_d = 1'b0;
            busy_d      = 1'b1;
            len_err_d   = 1'b0;
        end else begin
            if (w_accept) begin
                idx_d       = idx_q + 8'd1;
                out_valid_d = 1'b1;
                out_data_d  = in_data ^ w_ks;
                out_last_d  = in_last || w_overflow;
                if (in_last) begin
                    state_d = ST_IDLE;
                end else if (w_overflow) begin
                    state_d = ST_ERR;
                end
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end

            if (w_overflow) begin
                len_err_d = 1'b1;
                busy_d    = 1'b0;
            end else if (w_done) begin
                busy_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            key_q       <= 8'h00;
            idx_q       <= 8'h00;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            len_err_q   <= len_err_d;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = w_done;
    assign len_err   = len_err_q;

endmodule : hes_stream_decipher
`default_nettype wire

// File: doc/hes_stream_decipher.md
HES_STREAM_DECIPHER -- requirements
Module: hes_stream_decipher

Interface
REQ-001 Parameter MAX_LEN, default 256, SHALL set the maximum message length in bytes (legal range 1..256).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 key  input  8  SHALL be the message key, sampled only on the cycle new_message is high.
REQ-005 new_message  input  1  SHALL be a one-cycle pulse that starts a new message.
REQ-006 in_valid / in_ready  input / output  1 each  SHALL form the ciphertext-byte handshake.
REQ-007 in_data  input  8  SHALL be the ciphertext byte.
REQ-008 in_last  input  1  SHALL mark the final ciphertext byte.
REQ-009 out_valid / out_ready  output / input  1 each  SHALL form the plaintext-byte handshake.
REQ-010 out_data  output  8  SHALL be the recovered plaintext byte.
REQ-011 out_last  output  1  SHALL mark the final plaintext byte.
REQ-012 busy  output  1  SHALL be high while a message is in progress.
REQ-013 done  output  1  SHALL pulse for one cycle when the out_last byte is accepted downstream.
REQ-014 len_err  output  1  SHALL be a sticky flag set when a message exceeds MAX_LEN bytes.

Function
REQ-015 Keystream byte i SHALL equal SBOX[(key + i) mod 256], using the team S-box table; out_data SHALL equal in_data XOR keystream byte i.
REQ-016 The byte index SHALL be 8 bits, start at 0 on new_message, increment by 1 per accepted input byte, and wrap from 0xFF to 0x00 in the sum key+i.
REQ-017 FSM states SHALL be IDLE, RUN and ERR; reset state IDLE.
REQ-018 IDLE->RUN on new_message: latch key, clear index, assert busy.
REQ-019 RUN->IDLE when the in_last byte is accepted (in_valid && in_ready && in_last).
REQ-020 RUN->ERR when byte number MAX_LEN is accepted without in_last: set len_err, force out_last on that byte.
REQ-021 ERR->RUN on new_message; len_err SHALL clear only on rst or new_message.
REQ-022 in_ready SHALL be high only in RUN and when (!out_valid || out_ready); input bytes in IDLE or ERR SHALL be ignored.
REQ-023 Output SHALL be a single register stage: latency one cycle from input acceptance to out_valid; full throughput of one byte per cycle under continuous out_ready.
REQ-024 out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-025 new_message during RUN SHALL abort the current message: discard the untransmitted output byte, relatch key, clear index, and ignore in_valid on that cycle.
REQ-026 busy SHALL stay high from new_message until done (or until ERR is entered).

Reset
REQ-027 On rst: state IDLE; out_valid, out_last, done, len_err, busy = 0; out_data = 0x00; index = 0x00; latched key = 0x00; in_ready = 0.
REQ-028 rst mid-message SHALL drop all in-flight data; the next message requires new_message.

Structure
REQ-029 The 256-entry SBOX table, the FSM state enum and the MAX_LEN default SHALL reside in shared package hes_pkg, also used by the encrypting side.
REQ-030 Keystream generation SHALL be one sub-module, hes_keystream_gen: inputs are key and index, output is the keystream byte, combinational.

Verification
REQ-031 key=0x00, ciphertext 63 7C 77 with last on byte 3 -> plaintext 00 00 00, out_last on byte 3, done pulse once.
REQ-032 key=0xFF, ciphertext 16 63 -> plaintext 00 00; proves 0xFF->0x00 wrap in the index sum.
REQ-033 out_ready held low 5 cycles mid-stream -> in_ready low, out_data stable, no byte lost or duplicated.
REQ-034 MAX_LEN=4, 5 bytes sent without last -> byte 4 carries out_last, len_err=1, byte 5 not accepted.
REQ-035 new_message with key=0x01 asserted during byte 2 of a message -> next output byte uses SBOX[0x01]=0x7C.
REQ-036 rst asserted mid-message -> all outputs read zero on the next cycle, busy=0.
